// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// and presents the full difference and final borrow for a single done cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             d_bit
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_raw;
  logic             br_next;
  logic             last_bit;

  // One full-subtractor cell applied to the current LSBs of the operand shifters.
  assign d_raw    = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign last_bit = (cnt == LAST_BIT);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      r_sr       <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            r_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= {d_raw, r_sr[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          // The partial result stays internal; diff only changes once it is complete.
          if (last_bit) begin
            diff       <= {d_raw, r_sr[WIDTH-1:1]};
            borrow_out <= br_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state == SHIFT) || (state == DONE);
  assign done  = (state == DONE);
  assign d_bit = (state == SHIFT) ? d_raw : 1'b0;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor at WIDTH=8: latency,
// serial bit stream, borrow cases, ignored restarts, abort and back-to-back.
module tb_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int BUDGET = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             d_bit;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .d_bit(d_bit)
  );

  always #5 clk = ~clk;

  // Launches one operation from IDLE and waits (bounded) for done.
  // lat counts falling edges after the accepting edge; done seen at the
  // (WIDTH+1)th one means the done cycle ends on edge k+WIDTH+1.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       output logic [WIDTH-1:0] r_diff, output logic r_borrow,
                       output int lat, output logic [WIDTH-1:0] bits,
                       output logic busy_ok);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    lat = -1; bits = '0; busy_ok = 1'b1;
    for (int j = 1; j <= BUDGET; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (j <= WIDTH) bits[j-1] = d_bit;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) begin
        lat = j;
        break;
      end
    end
    r_diff = diff; r_borrow = borrow_out;
    @(negedge clk);
    if (busy !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 8'h07; b = 8'h02;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, done, diff, borrow_out, d_bit} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h borrow=%b d_bit=%b, want all 0",
               busy, done, diff, borrow_out, d_bit);
    end
    rst = 1'b0;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL first_start_after_reset: busy=%b want 1", busy);
    end
    for (int j = 0; j < BUDGET && done !== 1'b1; j++) @(negedge clk);
    total++;
    if (done !== 1'b1 || diff !== 8'h05 || borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL first_op: done=%b diff=%h borrow=%b want 1/05/0", done, diff, borrow_out);
    end
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [WIDTH-1:0] r; logic br; int lat; logic [WIDTH-1:0] bits; logic ok;
    do_op(8'h05, 8'h03, r, br, lat, bits, ok);
    total++;
    if (lat !== WIDTH + 1) begin
      bad++; $display("FAIL basic_latency: got %0d want %0d", lat, WIDTH + 1);
    end
    total++;
    if (r !== 8'h02 || br !== 1'b0) begin
      bad++; $display("FAIL basic_result: got %h/%b want 02/0", r, br);
    end
    total++;
    // d_bit stream 0,1,0,0,0,0,0,0 stored LSB-first
    if (bits !== 8'b0000_0010) begin
      bad++; $display("FAIL basic_dbits: got %b want 00000010", bits);
    end
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL basic_busy: got %b want 1", ok);
    end
  endtask

  task automatic test_vectors;
    logic [WIDTH-1:0] va [3] = '{8'h03, 8'h00, 8'hA5};
    logic [WIDTH-1:0] vb [3] = '{8'h05, 8'hFF, 8'hA5};
    logic [WIDTH-1:0] ed [3] = '{8'hFE, 8'h01, 8'h00};
    logic             eb [3] = '{1'b1, 1'b1, 1'b0};
    logic [WIDTH-1:0] r; logic br; int lat; logic [WIDTH-1:0] bits; logic ok;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], r, br, lat, bits, ok);
      total++;
      if (lat !== WIDTH + 1 || r !== ed[i] || br !== eb[i]) begin
        bad++;
        $display("FAIL vector_%0d: a=%h b=%h got lat=%0d diff=%h borrow=%b want lat=%0d diff=%h borrow=%b",
                 i, va[i], vb[i], lat, r, br, WIDTH + 1, ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int pulses = 0;
    logic [WIDTH-1:0] r = '0; logic br = 1'b0;
    @(negedge clk);
    a = 8'h80; b = 8'h01; start = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
      if (j == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
      if (j == 7) start = 1'b0;
      if (done === 1'b1) begin
        pulses++; r = diff; br = borrow_out;
      end
    end
    total++;
    if (pulses != 1) begin
      bad++; $display("FAIL ignore_pulses: got %0d want 1", pulses);
    end
    total++;
    if (r !== 8'h7F || br !== 1'b0) begin
      bad++; $display("FAIL ignore_result: got %h/%b want 7F/0", r, br);
    end
  endtask

  task automatic test_abort;
    int pulses = 0;
    logic [WIDTH-1:0] r; logic br; int lat; logic [WIDTH-1:0] bits; logic ok;
    @(negedge clk);
    a = 8'hFF; b = 8'h0F; start = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) start = 1'b0;
    end
    rst = 1'b1;  // applied during the 4th SHIFT cycle
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, done, diff, borrow_out, d_bit} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b diff=%h borrow=%b d_bit=%b, want all 0",
               busy, done, diff, borrow_out, d_bit);
    end
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    end
    do_op(8'h09, 8'h04, r, br, lat, bits, ok);
    total++;
    if (r !== 8'h05 || br !== 1'b0) begin
      bad++; $display("FAIL abort_next_op: got %h/%b want 05/0", r, br);
    end
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    int last = -1;
    int gap_bad = 0;
    int val_bad = 0;
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (last >= 0 && j - last != 10) gap_bad++;
        if (diff !== 8'h0F || borrow_out !== 1'b0) val_bad++;
        last = j;
      end
    end
    start = 1'b0;
    total++;
    if (pulses != 4 || gap_bad != 0) begin
      bad++; $display("FAIL b2b_cadence: pulses=%0d bad_gaps=%0d want 4/0", pulses, gap_bad);
    end
    total++;
    if (val_bad != 0) begin
      bad++; $display("FAIL b2b_values: %0d wrong results want 0", val_bad);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] av, bv, r, exp_d; logic br, exp_b; int lat;
    logic [WIDTH-1:0] bits; logic ok;
    int errs = 0;
    for (int i = 0; i < 1000; i++) begin
      av = WIDTH'($urandom_range(255));
      bv = WIDTH'($urandom_range(255));
      exp_d = av - bv;
      exp_b = (av < bv);
      do_op(av, bv, r, br, lat, bits, ok);
      total++;
      if (lat !== WIDTH + 1 || r !== exp_d || br !== exp_b || ok !== 1'b1) begin
        bad++; errs++;
        if (errs <= 5)
          $display("FAIL random_%0d: a=%h b=%h got lat=%0d diff=%h borrow=%b busy_ok=%b want %0d/%h/%b/1",
                   i, av, bv, lat, r, br, ok, WIDTH + 1, exp_d, exp_b);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
